// File: rtl/conv_stream_engine.sv
// Streaming KxK valid-mode convolution engine.
// Raster-order unsigned pixels in, signed saturated results out, both over valid/ready.
// Optional ReLU ahead of the shift is enabled by defining CONV_STREAM_RELU_EN.
module conv_stream_engine #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ACC_WIDTH     = 24,
    parameter int unsigned KERNEL        = 3,
    parameter int unsigned MAX_IMG_WIDTH = 64,
    localparam int unsigned IDX_W = (KERNEL * KERNEL > 1) ? $clog2(KERNEL * KERNEL) : 1,
    localparam int unsigned W_W   = $clog2(MAX_IMG_WIDTH + 1),
    localparam int unsigned SH_W  = $clog2(ACC_WIDTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wgt_we_i,
    input  logic [IDX_W-1:0]      wgt_idx_i,
    input  logic [DATA_WIDTH-1:0] wgt_data_i,
    input  logic [W_W-1:0]        img_width_i,
    input  logic [15:0]           img_height_i,
    input  logic [SH_W-1:0]       shift_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    input  logic                  pix_valid_i,
    output logic                  pix_ready_o,
    input  logic [DATA_WIDTH-1:0] pix_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_last_o
);

    localparam int unsigned NUM_WGT   = KERNEL * KERNEL;
    localparam int unsigned COL_IDX_W = (MAX_IMG_WIDTH > 1) ? $clog2(MAX_IMG_WIDTH) : 1;
    localparam int unsigned LB_ROWS   = (KERNEL > 1) ? KERNEL - 1 : 1;
    localparam int unsigned PROD_W    = 2 * DATA_WIDTH + 1;

    localparam logic [W_W-1:0]   K_W       = W_W'(KERNEL);
    localparam logic [W_W-1:0]   KM1_W     = W_W'(KERNEL - 1);
    localparam logic [W_W-1:0]   MAX_W     = W_W'(MAX_IMG_WIDTH);
    localparam logic [15:0]      K_H       = 16'(KERNEL);
    localparam logic [15:0]      KM1_H     = 16'(KERNEL - 1);
    localparam logic [IDX_W:0]   NUM_WGT_L = (IDX_W + 1)'(NUM_WGT);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {StIdle, StRun, StFlush} state_t;

    state_t                        state;
    logic [W_W-1:0]                w_reg;
    logic [15:0]                   h_reg;
    logic [SH_W-1:0]               shift_amt;
    logic [W_W-1:0]                col;
    logic [15:0]                   row;
    logic signed [DATA_WIDTH-1:0]  wgt     [NUM_WGT];
    logic [DATA_WIDTH-1:0]         lb      [LB_ROWS][MAX_IMG_WIDTH];
    logic [DATA_WIDTH-1:0]         win     [KERNEL][KERNEL];
    logic [DATA_WIDTH-1:0]         win_nxt [KERNEL][KERNEL];
    logic [DATA_WIDTH-1:0]         col_vec [KERNEL];

    logic                          accept;
    logic                          col_last;
    logic                          row_last;
    logic                          win_full;
    logic                          dims_ok;
    logic [COL_IDX_W-1:0]          col_idx;
    logic signed [PROD_W-1:0]      prod;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic signed [ACC_WIDTH-1:0]   shifted;
    logic [DATA_WIDTH-1:0]         sat_res;

    assign pix_ready_o = (state == StRun) && (!out_valid_o || out_ready_i);
    assign accept      = pix_valid_i && pix_ready_o;
    assign col_idx     = col[COL_IDX_W-1:0];
    assign col_last    = (col == w_reg - W_W'(1));
    assign row_last    = (row == h_reg - 16'd1);
    assign win_full    = (row >= KM1_H) && (col >= KM1_W);
    assign dims_ok     = (img_width_i >= K_W) && (img_width_i <= MAX_W) && (img_height_i >= K_H);

    // Window as it will look after the current pixel is shifted in; results use this view.
    always_comb begin
        for (int i = 0; i < KERNEL; i++) begin
            col_vec[i] = pix_data_i;
        end
        for (int i = 0; i < KERNEL - 1; i++) begin
            col_vec[i] = lb[i][col_idx];
        end
        for (int i = 0; i < KERNEL; i++) begin
            for (int j = 0; j < KERNEL - 1; j++) begin
                win_nxt[i][j] = win[i][j + 1];
            end
            win_nxt[i][KERNEL-1] = col_vec[i];
        end
    end

    // Multiply-accumulate, optional ReLU, arithmetic shift and saturation.
    always_comb begin
        acc  = '0;
        prod = '0;
        for (int i = 0; i < KERNEL; i++) begin
            for (int j = 0; j < KERNEL; j++) begin
                prod = $signed({1'b0, win_nxt[i][j]}) * wgt[i * KERNEL + j];
                acc  = acc + ACC_WIDTH'(prod);
            end
        end
`ifdef CONV_STREAM_RELU_EN
        if (acc[ACC_WIDTH-1]) begin
            acc = '0;
        end
`endif
        shifted = acc >>> shift_amt;
        if (shifted > SAT_MAX) begin
            sat_res = SAT_MAX[DATA_WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_res = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            sat_res = shifted[DATA_WIDTH-1:0];
        end
    end

    // Line buffers (row 0 = oldest) and the KxK shift window advance on each accepted pixel.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < LB_ROWS; i++) begin
                for (int c = 0; c < MAX_IMG_WIDTH; c++) begin
                    lb[i][c] <= '0;
                end
            end
            for (int i = 0; i < KERNEL; i++) begin
                for (int j = 0; j < KERNEL; j++) begin
                    win[i][j] <= '0;
                end
            end
        end else if (accept) begin
            for (int i = 0; i < LB_ROWS - 1; i++) begin
                lb[i][col_idx] <= lb[i + 1][col_idx];
            end
            lb[LB_ROWS-1][col_idx] <= pix_data_i;
            win <= win_nxt;
        end
    end

    // Frame FSM, counters, weight store and registered status/output stage.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= StIdle;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_last_o  <= 1'b0;
            w_reg       <= '0;
            h_reg       <= '0;
            shift_amt   <= '0;
            col         <= '0;
            row         <= '0;
            for (int i = 0; i < NUM_WGT; i++) begin
                wgt[i] <= '0;
            end
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state)
                StIdle: begin
                    if (wgt_we_i && ({1'b0, wgt_idx_i} < NUM_WGT_L)) begin
                        wgt[wgt_idx_i] <= wgt_data_i;
                    end
                    if (start_i) begin
                        if (dims_ok) begin
                            state     <= StRun;
                            busy_o    <= 1'b1;
                            w_reg     <= img_width_i;
                            h_reg     <= img_height_i;
                            shift_amt <= shift_i;
                            col       <= '0;
                            row       <= '0;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (out_valid_o && out_ready_i) begin
                        out_valid_o <= 1'b0;
                    end
                    if (accept) begin
                        if (win_full) begin
                            out_valid_o <= 1'b1;
                            out_data_o  <= sat_res;
                            out_last_o  <= row_last && col_last;
                        end
                        if (col_last) begin
                            col <= '0;
                            row <= row + 16'd1;
                            if (row_last) begin
                                state <= StFlush;
                            end
                        end else begin
                            col <= col + W_W'(1);
                        end
                    end
                end
                StFlush: begin
                    // The final pixel always completes a window, so the held result is the last.
                    if (out_valid_o && out_ready_i) begin
                        out_valid_o <= 1'b0;
                        out_last_o  <= 1'b0;
                        done_o      <= 1'b1;
                        busy_o      <= 1'b0;
                        state       <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_stream_engine.sv
// Directed self-checking bench for conv_stream_engine (K=3, 8-bit data, 24-bit accumulator).
// Expected values for the ReLU scenario follow CONV_STREAM_RELU_EN.
module tb_conv_stream_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wgt_we;
    logic [3:0] wgt_idx;
    logic [7:0] wgt_data;
    logic [6:0] img_width;
    logic [15:0] img_height;
    logic [4:0] shift;
    logic       start;
    logic       busy, done, err;
    logic       pix_valid, pix_ready;
    logic [7:0] pix_data;
    logic       out_valid, out_ready, out_last;
    logic [7:0] out_data;

    int checks = 0;
    int failures = 0;

    logic [7:0] pix_mem [64];
    logic [7:0] wgt_tab [9];
    logic [7:0] exp_tab [4];
    logic [7:0] res_q [$];
    logic       res_last [$];

    always #5 clk = ~clk;

    conv_stream_engine dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .wgt_we_i     (wgt_we),
        .wgt_idx_i    (wgt_idx),
        .wgt_data_i   (wgt_data),
        .img_width_i  (img_width),
        .img_height_i (img_height),
        .shift_i      (shift),
        .start_i      (start),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .pix_valid_i  (pix_valid),
        .pix_ready_o  (pix_ready),
        .pix_data_i   (pix_data),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .out_last_o   (out_last)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, expv);
        end
    endtask

    task automatic load_weights();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            wgt_we   = 1'b1;
            wgt_idx  = 4'(i);
            wgt_data = wgt_tab[i];
        end
        @(negedge clk);
        wgt_we = 1'b0;
    endtask

    // Runs one frame; optional output stall after the first result and weight pokes during RUN.
    task automatic run_frame(input int w, input int h, input logic [4:0] sh, input int stall,
                             input bit poke);
        int idx = 0;
        int cyc = 0;
        int stall_left = stall;
        int last_cyc = -1;
        int done_cyc = -1;
        res_q.delete();
        res_last.delete();
        @(negedge clk);
        img_width  = 7'(w);
        img_height = 16'(h);
        shift      = sh;
        start      = 1'b1;
        pix_valid  = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("busy_in_run", busy, 1);
        while (done_cyc < 0 && cyc < 400) begin
            pix_valid = (idx < w * h);
            pix_data  = (idx < 64) ? pix_mem[idx] : 8'd0;
            out_ready = (stall_left == 0);
            wgt_we    = poke && (last_cyc < 0);
            wgt_idx   = 4'd0;
            wgt_data  = 8'd100;
            #1;
            if (stall_left > 0 && out_valid) begin
                check("stall_hold_data", out_data, 45);
                check("stall_pix_ready", pix_ready, 0);
                stall_left--;
            end
            if (out_valid && out_ready) begin
                res_q.push_back(out_data);
                res_last.push_back(out_last);
                if (out_last) last_cyc = cyc;
            end
            if (pix_valid && pix_ready) idx++;
            if (done) done_cyc = cyc;
            @(negedge clk);
            cyc++;
        end
        pix_valid = 1'b0;
        wgt_we    = 1'b0;
        out_ready = 1'b1;
        #1;
        check("done_after_last", done_cyc - last_cyc, 1);
        check("done_one_cycle", done, 0);
        check("busy_after_frame", busy, 0);
        check("pixels_accepted", idx, w * h);
    endtask

    task automatic check_seq(input string tag, input int n);
        check({tag, "_count"}, res_q.size(), n);
        for (int k = 0; k < n; k++) begin
            if (k < res_q.size()) begin
                check({tag, "_data"}, res_q[k], exp_tab[k]);
                check({tag, "_last"}, res_last[k], (k == n - 1));
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        wgt_we     = 1'b0;
        wgt_idx    = '0;
        wgt_data   = '0;
        img_width  = '0;
        img_height = '0;
        shift      = '0;
        start      = 1'b0;
        pix_valid  = 1'b0;
        pix_data   = '0;
        out_ready  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, done, err, out_valid, pix_ready, out_last, out_data}, 0);
        rst_n = 1'b1;

        // Out-of-range weight index must be dropped.
        @(negedge clk);
        wgt_we = 1'b1; wgt_idx = 4'd15; wgt_data = 8'd50;
        @(negedge clk);
        wgt_we = 1'b0;

        // 4x4 ramp, all-ones weights.
        for (int i = 0; i < 9; i++) wgt_tab[i] = 8'd1;
        load_weights();
        for (int i = 0; i < 16; i++) pix_mem[i] = 8'(i);
        exp_tab[0] = 8'd45; exp_tab[1] = 8'd54; exp_tab[2] = 8'd81; exp_tab[3] = 8'd90;
        run_frame(4, 4, 5'd0, 0, 1'b0);
        check_seq("ramp", 4);

        // Saturation and shift with all-255 pixels.
        for (int i = 0; i < 16; i++) pix_mem[i] = 8'd255;
        run_frame(3, 3, 5'd0, 0, 1'b0);
        exp_tab[0] = 8'd127;
        check_seq("sat_shift0", 1);
        run_frame(3, 3, 5'd5, 0, 1'b0);
        exp_tab[0] = 8'd71;
        check_seq("sat_shift5", 1);

        // Negative centre tap.
        for (int i = 0; i < 9; i++) wgt_tab[i] = 8'd0;
        wgt_tab[4] = 8'hFF;
        load_weights();
        for (int i = 0; i < 16; i++) pix_mem[i] = 8'd10;
        run_frame(3, 3, 5'd0, 0, 1'b0);
`ifdef CONV_STREAM_RELU_EN
        exp_tab[0] = 8'd0;
`else
        exp_tab[0] = 8'hF6;
`endif
        check_seq("neg_centre", 1);

        // Output back-pressure on the ramp frame.
        for (int i = 0; i < 9; i++) wgt_tab[i] = 8'd1;
        load_weights();
        for (int i = 0; i < 16; i++) pix_mem[i] = 8'(i);
        exp_tab[0] = 8'd45; exp_tab[1] = 8'd54; exp_tab[2] = 8'd81; exp_tab[3] = 8'd90;
        run_frame(4, 4, 5'd0, 5, 1'b0);
        check_seq("stall", 4);

        // Rejected starts: width too small, then too large.
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            img_width  = (t == 0) ? 7'd2 : 7'd65;
            img_height = 16'd4;
            start      = 1'b1;
            pix_valid  = 1'b1;
            @(negedge clk);
            start = 1'b0;
            #1;
            check("err_pulse", err, 1);
            check("err_not_busy", busy, 0);
            check("err_no_ready", pix_ready, 0);
            @(negedge clk);
            #1;
            check("err_one_cycle", err, 0);
            pix_valid = 1'b0;
        end

        // Mid-frame reset after 7 pixels, with weight pokes during RUN.
        @(negedge clk);
        img_width = 7'd4; img_height = 16'd4; shift = 5'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            pix_valid = 1'b1;
            pix_data  = pix_mem[k];
            wgt_we    = 1'b1; wgt_idx = 4'd0; wgt_data = 8'd100;
            #1;
            check("partial_ready", pix_ready, 1);
            @(negedge clk);
        end
        pix_valid = 1'b0;
        wgt_we    = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midreset_idle", {busy, done, out_valid, pix_ready}, 0);
        load_weights();
        run_frame(4, 4, 5'd0, 0, 1'b1);
        check_seq("rerun", 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
